// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and the oversampling ratio.
// Used by both the transmitter and the receiver.
package uart_pkg;

  // Number of s_tick pulses per bit period.
  localparam int OVERSAMPLE = 16;

  // Frame sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: one start bit, DBIT data bits LSB-first, no parity,
// and a stop period of SB_TICK oversampling ticks. Bit timing is driven by
// the external s_tick (OVERSAMPLE ticks per bit). The tx line is registered
// and idles high.
//
// Handshake: tx_ready is high exactly when the block is in IDLE. A cycle with
// tx_ready=1 and tx_start=1 accepts din (captured that cycle); tx_start in any
// other cycle is ignored and not queued. tx_done_tick pulses for one clk in
// the cycle of the final stop-period s_tick; tx_ready rises the cycle after.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tx_start,
  input  logic            s_tick,
  input  logic [DBIT-1:0] din,
  output logic            tx_ready,
  output logic            tx_done_tick,
  output logic            tx,
  output uart_state_e     state_o
);

  // Tick counter must reach both OVERSAMPLE-1 and SB_TICK-1.
  localparam int SW = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);
  // Bit index counter; at least one bit wide so DBIT=1 still builds.
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  uart_state_e     state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            tx_q, tx_d;
  logic            done;

  // State, counters, shift register and line register; reset forces the
  // line high immediately so an aborted frame never leaves tx low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state logic; tx_d is taken from the next state so the line value
  // of a state appears on the same edge that enters it.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    done    = 1'b0;
    tx_d    = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (tx_start) begin
          state_d = START;
          s_d     = '0;
          b_d     = din;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            state_d = DATA;
            s_d     = '0;
            n_d     = '0;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP_LAST) begin
            state_d = IDLE;
            done    = 1'b1;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = b_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx           = tx_q;
  assign tx_ready     = (state_q == IDLE);
  assign tx_done_tick = done;
  assign state_o      = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a frame-level reference model (tick
// position within the frame -> expected line level) checked every clk,
// plus hand-computed literal expectations for the directed scenarios.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int DBIT        = 8;
  localparam int SB_TICK     = 16;
  localparam int OS          = 16;
  localparam int FRAME_TICKS = OS + OS * DBIT + SB_TICK;

  // ---------------- clock / reset / DUT ----------------
  logic            clk      = 1'b0;
  logic            reset    = 1'b0;
  logic            tx_start = 1'b0;
  logic            s_tick   = 1'b0;
  logic [DBIT-1:0] din      = '0;
  logic            tx_ready;
  logic            tx_done_tick;
  logic            tx;
  uart_state_e     state_o;

  initial forever #5 clk = ~clk;

  uart_tx #(.DBIT(DBIT), .SB_TICK(SB_TICK)) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_start     (tx_start),
    .s_tick       (s_tick),
    .din          (din),
    .tx_ready     (tx_ready),
    .tx_done_tick (tx_done_tick),
    .tx           (tx),
    .state_o      (state_o)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- tick generator ----------------
  // 0: tied high, 1: mod-2 baud counter, 2: random ticks
  int tick_mode = 0;
  initial begin
    int c;
    c = 0;
    forever begin
      @(posedge clk);
      #1;
      case (tick_mode)
        0: s_tick = 1'b1;
        1: begin c = (c + 1) % 2; s_tick = (c == 1); end
        default: s_tick = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  // ---------------- reference model ----------------
  logic [DBIT-1:0] exp_q[$];   // accepted frames, head is the one in flight
  logic m_busy = 1'b0;
  int   m_t = 0;               // s_ticks consumed in the current frame
  int   m_frames_done = 0;
  int   dut_done_cnt = 0;

  function automatic logic frame_level(input int t, input logic [DBIT-1:0] d);
    if (t < OS) return 1'b0;
    if (t < OS + OS * DBIT) return d[(t - OS) / OS];
    return 1'b1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0;
      m_t    <= 0;
      exp_q.delete();
    end else if (m_busy) begin
      if (s_tick) begin
        if (m_t == FRAME_TICKS - 1) begin
          m_busy <= 1'b0;
          void'(exp_q.pop_front());
          m_frames_done <= m_frames_done + 1;
        end else begin
          m_t <= m_t + 1;
        end
      end
    end else if (tx_start) begin
      m_busy <= 1'b1;
      m_t    <= 0;
      exp_q.push_back(din);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic exp_tx, exp_done;
    if (reset) begin
      exp_tx   = m_busy ? frame_level(m_t, exp_q[0]) : 1'b1;
      exp_done = m_busy && s_tick && (m_t == FRAME_TICKS - 1);
      check("tx", 32'(tx), 32'(exp_tx));
      check("tx_ready", 32'(tx_ready), 32'(!m_busy));
      check("tx_done_tick", 32'(tx_done_tick), 32'(exp_done));
      if (tx_done_tick) dut_done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [DBIT-1:0] d);
    int w;
    w = 0;
    while (!tx_ready && w < 2000) begin step(); w++; end
    if (!tx_ready) begin
      n_vec++; n_miss++;
      $display("FAIL send_wait: tx_ready got 0 expected 1 within 2000 clks");
    end
    tx_start = 1'b1;
    din      = d;
    step();
    tx_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int w;
    w = 0;
    do begin step(); w++; end while (!tx_done_tick && w < budget);
    if (!tx_done_tick) begin
      n_vec++; n_miss++;
      $display("FAIL wait_done: tx_done_tick got 0 expected 1 within %0d clks", budget);
    end
  endtask

  task automatic wait_state(input uart_state_e s, input int budget);
    int w;
    w = 0;
    while (state_o != s && w < budget) begin step(); w++; end
    if (state_o != s) begin
      n_vec++; n_miss++;
      $display("FAIL wait_state: state got %0d expected %0d", state_o, s);
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  logic rec_tx[0:199];
  logic rec_done[0:199];
  int   a5_seq[8] = '{1, 0, 1, 0, 0, 1, 0, 1};   // 8'hA5 sent LSB first

  initial begin
    int low_run, w, done_before;

    // Reset held with tx_start high
    tick_mode = 0;
    reset     = 1'b0;
    tx_start  = 1'b1;
    din       = DBIT'($urandom);
    repeat (3) step();
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_done", 32'(tx_done_tick), 32'd0);
    tx_start = 1'b0;
    reset    = 1'b1;
    repeat (3) step();
    check("post_rst_idle", 32'(state_o), 32'(IDLE));
    check("post_rst_ready", 32'(tx_ready), 32'd1);

    // Single frame 8'hA5, s_tick tied high; din disturbed mid-frame
    send(8'hA5);
    for (int k = 1; k < 200; k++) begin
      @(negedge clk);
      rec_tx[k]   = tx;
      rec_done[k] = tx_done_tick;
      if (k == 40) din = 8'h5A;
    end
    check("a5_start_first", 32'(rec_tx[1]), 32'd0);
    check("a5_start_last", 32'(rec_tx[16]), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("a5_bit%0d_first", i), 32'(rec_tx[17 + 16 * i]), 32'(a5_seq[i]));
      check($sformatf("a5_bit%0d_last", i), 32'(rec_tx[32 + 16 * i]), 32'(a5_seq[i]));
    end
    check("a5_stop_first", 32'(rec_tx[145]), 32'd1);
    check("a5_stop_last", 32'(rec_tx[160]), 32'd1);
    // 160th cycle after the acceptance cycle (161st counting acceptance as 1)
    check("a5_done_early", 32'(rec_done[159]), 32'd0);
    check("a5_done_at", 32'(rec_done[160]), 32'd1);
    check("a5_done_after", 32'(rec_done[161]), 32'd0);

    // Mod-2 baud tick, din=00: start+8 data bits low for 287 or 288 clks
    tick_mode = 1;
    step();
    send(8'h00);
    low_run = 0;
    w = 0;
    while (!tx_ready && w < 1000) begin
      @(negedge clk);
      if (tx == 1'b0) low_run++;
      din = DBIT'($urandom);
      step();
      w++;
    end
    n_vec++;
    if (low_run != 287 && low_run != 288) begin
      n_miss++;
      $display("FAIL m2_low_run: got %0d expected 287 or 288", low_run);
    end

    // Back-to-back: tx_start in done cycle ignored, first IDLE cycle accepted
    tick_mode = 0;
    step();
    send(DBIT'($urandom));
    wait_done(400);
    tx_start = 1'b1;
    din      = 8'hC3;
    step();
    check("b2b_ready_first_idle", 32'(tx_ready), 32'd1);
    check("b2b_tx_stop_still", 32'(tx), 32'd1);
    din = 8'h3C;
    step();
    tx_start = 1'b0;
    check("b2b_start_bit", 32'(tx), 32'd0);
    check("b2b_busy", 32'(tx_ready), 32'd0);
    wait_done(400);

    // Busy drop: tx_start during DATA has no effect
    tick_mode = 2;
    step();
    send(DBIT'($urandom));
    wait_state(DATA, 200);
    tx_start = 1'b1;
    din      = DBIT'($urandom);
    step();
    tx_start = 1'b0;
    check("busy_drop_state", 32'(state_o), 32'(DATA));
    wait_done(2000);

    // Reset mid-DATA: line returns high at once, no done pulse
    tick_mode = 0;
    step();
    send(8'h00);
    wait_state(DATA, 200);
    repeat (5) step();
    check("pre_rst_tx_low", 32'(tx), 32'd0);
    done_before = dut_done_cnt;
    reset = 1'b0;
    #1;
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_done", 32'(tx_done_tick), 32'd0);
    repeat (2) step();
    reset = 1'b1;
    repeat (3) step();
    check("mid_rst_no_done", 32'(dut_done_cnt), 32'(done_before));
    check("mid_rst_idle", 32'(state_o), 32'(IDLE));
    send(8'hFF);
    wait_done(400);

    // Random frames with random gaps, tick patterns and busy tx_start pulses
    for (int f = 0; f < 20; f++) begin
      tick_mode = $urandom_range(0, 2);
      repeat ($urandom_range(0, 5)) step();
      send(DBIT'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 100)) step();
        tx_start = 1'b1;
        din      = DBIT'($urandom);
        step();
        tx_start = 1'b0;
      end
      if (!tx_ready) wait_done(2000);
    end
    repeat (3) step();

    check("done_count", 32'(dut_done_cnt), 32'(m_frames_done));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
